// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, instruction memory read, IF/ID register, stall/redirect/halt
module instruction_fetch_unit #(
    parameter int              DEPTH    = 32,
    parameter int              WL       = 32,
    parameter logic [31:0]     RESET_PC = 32'h0000_0000,
    parameter logic [WL-1:0]   NOP      = WL'(32'h0000_0013),
    localparam int             AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [WL-1:0] imem_data,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_target,
    input  logic          halt_req,
    output logic [WL-1:0] if_id_instr,
    output logic [31:0]   if_id_pc,
    output logic          if_id_valid,
    output logic          halted,
    output logic          misalign_err,
    output logic [31:0]   fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [WL-1:0] instr_q, instr_d;
    logic [31:0]   ipc_q, ipc_d;
    logic          valid_q, valid_d;
    logic          mis_q, mis_d;
    logic [31:0]   count_q, count_d;

    logic [AW-1:0] word_next;
    logic [31:0]   pc_inc;

    // Incrementing through the word index wraps at DEPTH and drops any high PC bits.
    assign word_next = pc_q[AW+1:2] + AW'(1);
    assign pc_inc    = {{(30-AW){1'b0}}, word_next, 2'b00};
    assign imem_addr = pc_q[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            ipc_q   <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        count_d = count_q;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end else if (redirect_valid) begin
                    // Squash the wrong-path slot; the target is fetched next cycle.
                    pc_d    = {redirect_target[31:2], 2'b00};
                    instr_d = NOP;
                    valid_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end
                end else if (!stall) begin
                    instr_d = imem_data;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    count_d = count_q + 32'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign if_id_instr  = instr_q;
    assign if_id_pc     = ipc_q;
    assign if_id_valid  = valid_q;
    assign halted       = (state_q == HALTED);
    assign misalign_err = mis_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam int          DEPTH = 32;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [4:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:DEPTH-1];

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_halted;
    logic        m_mis;
    logic [31:0] m_count;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] m_addr();
        return 5'((m_pc / 4) % DEPTH);
    endfunction

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] rt, input logic h);
        rst = r; stall = s; redirect_valid = rv; redirect_target = rt; halt_req = h;
        @(posedge clk);
        if (r) begin
            m_pc = 32'd0; m_instr = NOPW; m_ipc = 32'd0; m_valid = 1'b0;
            m_halted = 1'b0; m_mis = 1'b0; m_count = 32'd0;
        end else if (m_halted) begin
        end else if (h) begin
            m_halted = 1'b1; m_instr = NOPW; m_valid = 1'b0;
        end else if (rv) begin
            m_pc = rt & 32'hFFFF_FFFC; m_instr = NOPW; m_valid = 1'b0;
            if (rt % 4 != 0) m_mis = 1'b1;
        end else if (!s) begin
            m_instr = mem[m_addr()]; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = (m_pc + 4) % (4 * DEPTH);
            m_count = m_count + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        rst = 0;
        vectors++; if (if_id_instr !== NOPW) begin miscompares++; $display("FAIL reset_instr got %h exp %h", if_id_instr, NOPW); end
        vectors++; if (if_id_pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end
        vectors++; if (if_id_valid !== 1'b0 || halted !== 1'b0 || misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_flags got v=%b h=%b m=%b exp 0 0 0", if_id_valid, halted, misalign_err); end
        vectors++; if (fetch_count !== 32'd0 || imem_addr !== 5'd0) begin miscompares++; $display("FAIL reset_count got cnt=%0d addr=%0d exp 0 0", fetch_count, imem_addr); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            vectors++; if (if_id_instr !== 32'(100 + i) || if_id_pc !== 32'(4 * i) || if_id_valid !== 1'b1) begin
                miscompares++; $display("FAIL seq_%0d got instr=%0d pc=%h v=%b exp %0d %h 1", i, if_id_instr, if_id_pc, if_id_valid, 100 + i, 4 * i);
            end
        end
        vectors++; if (fetch_count !== 32'd4) begin miscompares++; $display("FAIL seq_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            vectors++; if (imem_addr !== 5'd2 || if_id_instr !== 32'd101 || if_id_pc !== 32'd4 || if_id_valid !== 1'b1 || fetch_count !== 32'd2) begin
                miscompares++; $display("FAIL stall_%0d got addr=%0d instr=%0d pc=%h v=%b cnt=%0d exp 2 101 4 1 2", i, imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_count);
            end
        end
        step(0, 0, 0, 0, 0);
        vectors++; if (if_id_instr !== 32'd102 || if_id_pc !== 32'd8 || fetch_count !== 32'd3) begin
            miscompares++; $display("FAIL stall_release got instr=%0d pc=%h cnt=%0d exp 102 8 3", if_id_instr, if_id_pc, fetch_count);
        end
    endtask

    task automatic test_redirect_stall();
        step(0, 1, 1, 32'h40, 0);
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== NOPW || imem_addr !== 5'd16 || fetch_count !== 32'd3) begin
            miscompares++; $display("FAIL redir_squash got v=%b instr=%h addr=%0d cnt=%0d exp 0 %h 16 3", if_id_valid, if_id_instr, imem_addr, fetch_count, NOPW);
        end
        step(0, 0, 0, 0, 0);
        vectors++; if (if_id_instr !== 32'd116 || if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin
            miscompares++; $display("FAIL redir_target got instr=%0d pc=%h v=%b exp 116 40 1", if_id_instr, if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_misalign();
        step(0, 0, 1, 32'h46, 0);
        vectors++; if (imem_addr !== 5'd17 || misalign_err !== 1'b1) begin
            miscompares++; $display("FAIL misalign_set got addr=%0d err=%b exp 17 1", imem_addr, misalign_err);
        end
        step(0, 0, 1, 32'h10, 0);
        step(0, 0, 0, 0, 0);
        vectors++; if (misalign_err !== 1'b1 || if_id_pc !== 32'h10) begin
            miscompares++; $display("FAIL misalign_sticky got err=%b pc=%h exp 1 10", misalign_err, if_id_pc);
        end
        step(1, 0, 0, 0, 0);
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got %b exp 0", misalign_err); end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'h7C, 0);
        step(0, 0, 0, 0, 0);
        vectors++; if (if_id_pc !== 32'h7C || if_id_instr !== 32'd131 || imem_addr !== 5'd0) begin
            miscompares++; $display("FAIL wrap_last got pc=%h instr=%0d addr=%0d exp 7c 131 0", if_id_pc, if_id_instr, imem_addr);
        end
        step(0, 0, 0, 0, 0);
        vectors++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'd100) begin
            miscompares++; $display("FAIL wrap_first got pc=%h instr=%0d exp 0 100", if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_halt();
        logic [4:0]  addr0;
        logic [31:0] cnt0;
        step(0, 0, 0, 0, 0);
        addr0 = imem_addr;
        cnt0  = fetch_count;
        step(0, 0, 1, 32'h21, 1);
        vectors++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || if_id_instr !== NOPW || imem_addr !== addr0 || misalign_err !== 1'b0) begin
            miscompares++; $display("FAIL halt_enter got h=%b v=%b instr=%h addr=%0d err=%b exp 1 0 %h %0d 0", halted, if_id_valid, if_id_instr, imem_addr, misalign_err, NOPW, addr0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, i[0], 1, 32'h50, 0);
            vectors++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== addr0 || fetch_count !== cnt0) begin
                miscompares++; $display("FAIL halt_hold_%0d got h=%b v=%b addr=%0d cnt=%0d exp 1 0 %0d %0d", i, halted, if_id_valid, imem_addr, fetch_count, addr0, cnt0);
            end
        end
        step(1, 0, 0, 0, 0);
        vectors++; if (halted !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 5'd0) begin
            miscompares++; $display("FAIL halt_reset got h=%b cnt=%0d addr=%0d exp 0 0 0", halted, fetch_count, imem_addr);
        end
        step(0, 0, 0, 0, 0);
        vectors++; if (if_id_pc !== 32'd0 || if_id_instr !== 32'd100 || if_id_valid !== 1'b1) begin
            miscompares++; $display("FAIL halt_resume got pc=%h instr=%0d v=%b exp 0 100 1", if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), 32'($urandom_range(0, 127)),
                 ($urandom_range(0, 99) == 0));
            vectors++;
            if (imem_addr !== m_addr() || if_id_instr !== m_instr || if_id_pc !== m_ipc ||
                if_id_valid !== m_valid || halted !== m_halted || misalign_err !== m_mis ||
                fetch_count !== m_count) begin
                miscompares++;
                $display("FAIL random_%0d got addr=%0d instr=%h pc=%h v=%b h=%b m=%b cnt=%0d exp %0d %h %h %b %b %b %0d",
                         i, imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, misalign_err, fetch_count,
                         m_addr(), m_instr, m_ipc, m_valid, m_halted, m_mis, m_count);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        m_pc = 0; m_instr = NOPW; m_ipc = 0; m_valid = 0; m_halted = 0; m_mis = 0; m_count = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
